// File: rtl/calc_pkg.sv
// Shared sizing helpers for panel-derived instance parameters.
package calc_pkg;

  // Lanes = number of stacked subpanels times bytes stored per pixel.
  function automatic int unsigned num_lanes(input int unsigned pixel_height,
                                            input int unsigned bytes_per_pixel,
                                            input int unsigned pixel_halfheight);
    if (pixel_halfheight == 0) return bytes_per_pixel;
    return (pixel_height / pixel_halfheight) * bytes_per_pixel;
  endfunction

endpackage

// File: rtl/multimem_pkg.sv
// Types and helpers shared by the double-buffered banked framebuffer.
package multimem_pkg;

  typedef enum logic {IDLE, CLEAR} multimem_dbuf_state_e;

  localparam int unsigned DEFAULT_PIPE_EXTRA = 0;

  function automatic int unsigned lane_sel_bits(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/multimem_dbuf_if.sv
// Writer / scanner / swap / clear signal bundle for multimem_dbuf.
interface multimem_dbuf_if
  import multimem_pkg::*;
#(
  parameter int unsigned LANES     = 8,
  parameter int unsigned DW        = 8,
  parameter int unsigned ADDR_BITS = 11
);
  localparam int unsigned LSB = lane_sel_bits(LANES);

  logic                   wr_valid;
  logic                   wr_ready;
  logic [LSB-1:0]         wr_lane;
  logic [ADDR_BITS-1:0]   wr_addr;
  logic [DW-1:0]          wr_data;
  logic                   rd_en;
  logic [ADDR_BITS-1:0]   rd_addr;
  logic [LANES*DW-1:0]    rd_data;
  logic                   rd_valid;
  logic                   frame_end;
  logic                   swap_req;
  logic                   swap_pending;
  logic                   swap_ack;
  logic                   front_sel;
  logic                   clear_req;
  logic                   clear_busy;

  modport master (
    output wr_valid, wr_lane, wr_addr, wr_data, rd_en, rd_addr,
           frame_end, swap_req, clear_req,
    input  wr_ready, rd_data, rd_valid, swap_pending, swap_ack,
           front_sel, clear_busy
  );

  modport slave (
    input  wr_valid, wr_lane, wr_addr, wr_data, rd_en, rd_addr,
           frame_end, swap_req, clear_req,
    output wr_ready, rd_data, rd_valid, swap_pending, swap_ack,
           front_sel, clear_busy
  );

endinterface

// File: rtl/mem_lane.sv
// One lane of framebuffer storage: simple dual-port RAM, registered read.
module mem_lane #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/multimem_dbuf.sv
// Double-buffered banked framebuffer; buffer bit is the lane address MSB.
// Optional back-buffer clear engine enabled by MULTIMEM_DBUF_CLEAR_EN.
module multimem_dbuf
  import multimem_pkg::*;
#(
  parameter int unsigned    LANES       = 8,
  parameter int unsigned    DW          = 8,
  parameter int unsigned    ADDR_BITS   = 11,
  parameter int unsigned    PIPE_EXTRA  = DEFAULT_PIPE_EXTRA,
  parameter logic [DW-1:0]  CLEAR_VALUE = '0
) (
  input logic             clk,
  input logic             rst,
  multimem_dbuf_if.slave  bus
);

  localparam int unsigned LSB = lane_sel_bits(LANES);
  localparam int unsigned AW  = ADDR_BITS + 1;

  multimem_dbuf_state_e state_q, state_n;
  logic                 front_q, pend_q;
  logic                 clearing, commit;

  logic                 wv_q;
  logic [LSB-1:0]       wlane_q;
  logic [AW-1:0]        waddr_q;
  logic [DW-1:0]        wdata_q;

  logic [LANES-1:0]     lane_we;
  logic [AW-1:0]        mem_waddr;
  logic [DW-1:0]        mem_wdata;
  logic [LANES*DW-1:0]  mem_q;

  logic                              rv1_q;
  logic [PIPE_EXTRA:0]               pv_q;
  logic [PIPE_EXTRA:0][LANES*DW-1:0] pd_q;

  assign clearing = (state_q == CLEAR);
  assign commit   = ~rst & pend_q & bus.frame_end & ~clearing;

  assign bus.wr_ready     = ~rst & ~clearing;
  assign bus.swap_ack     = commit;
  assign bus.swap_pending = pend_q;
  assign bus.front_sel    = front_q;
  assign bus.clear_busy   = clearing;
  assign bus.rd_data      = pd_q[PIPE_EXTRA];
  assign bus.rd_valid     = pv_q[PIPE_EXTRA];

  always_ff @(posedge clk) begin
    if (rst) begin
      front_q <= 1'b0;
      pend_q  <= 1'b0;
    end else if (commit) begin
      front_q <= ~front_q;
      pend_q  <= 1'b0;
    end else if (bus.swap_req) begin
      pend_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

`ifdef MULTIMEM_DBUF_CLEAR_EN
  logic [ADDR_BITS-1:0] clr_addr_q;

  always_ff @(posedge clk) begin
    if (rst || !clearing) clr_addr_q <= '0;
    else                  clr_addr_q <= clr_addr_q + 1'b1;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:    if (bus.clear_req) state_n = CLEAR;
      CLEAR:   if (clr_addr_q == '1) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
`else
  logic unused_clear_req;
  assign unused_clear_req = bus.clear_req;

  always_comb begin
    state_n = IDLE;
  end
`endif

  // A write landing in the clear's first cycle is dropped: the clear
  // overwrites that back buffer anyway.
  always_comb begin
    lane_we   = '0;
    mem_waddr = waddr_q;
    mem_wdata = wdata_q;
`ifdef MULTIMEM_DBUF_CLEAR_EN
    if (clearing) begin
      lane_we   = '1;
      mem_waddr = {~front_q, clr_addr_q};
      mem_wdata = CLEAR_VALUE;
    end else
`endif
    if (wv_q) lane_we[wlane_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) wv_q <= 1'b0;
    else     wv_q <= bus.wr_valid & bus.wr_ready;
  end

  always_ff @(posedge clk) begin
    if (bus.wr_valid & bus.wr_ready) begin
      wlane_q <= bus.wr_lane;
      waddr_q <= {~front_q, bus.wr_addr};
      wdata_q <= bus.wr_data;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mem_lane #(.DW(DW), .AW(AW)) u_lane (
      .clk   (clk),
      .we    (lane_we[i]),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .re    (bus.rd_en),
      .raddr ({front_q, bus.rd_addr}),
      .rdata (mem_q[i*DW +: DW])
    );
  end

  // Each stage loads only with its valid so rd_data holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rv1_q <= 1'b0;
      pv_q  <= '0;
      pd_q  <= '0;
    end else begin
      rv1_q   <= bus.rd_en;
      pv_q[0] <= rv1_q;
      if (rv1_q) pd_q[0] <= mem_q;
      for (int unsigned k = 1; k <= PIPE_EXTRA; k++) begin
        pv_q[k] <= pv_q[k-1];
        if (pv_q[k-1]) pd_q[k] <= pd_q[k-1];
      end
    end
  end

endmodule

// File: tb/tb_multimem_dbuf.sv
// Self-checking bench for multimem_dbuf against a buffer-level reference model.
module tb_multimem_dbuf;
  import multimem_pkg::*;

  localparam int unsigned LANES = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned AB    = 4;
  localparam int unsigned PE    = 2;
  localparam int unsigned LAT   = PE + 2;
  localparam int unsigned DEPTH = 1 << AB;
  localparam int unsigned LSB   = lane_sel_bits(LANES);
  localparam logic [DW-1:0] CV  = 8'h3C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multimem_dbuf_if #(.LANES(LANES), .DW(DW), .ADDR_BITS(AB)) bus ();

  multimem_dbuf #(
    .LANES(LANES), .DW(DW), .ADDR_BITS(AB), .PIPE_EXTRA(PE), .CLEAR_VALUE(CV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: whole buffers as arrays, reads as a due-time queue.
  typedef struct { int due; logic [LANES*DW-1:0] d; } rd_t;
  logic [DW-1:0]       mem_m [2][LANES][DEPTH];
  bit                  front_m, pend_m, ack_seen;
  int                  clr_m;
  int                  edge_n;
  rd_t                 rq[$];
  logic [LANES*DW-1:0] last_m;
  int                  checks, failures;

  typedef struct { bit sr; bit fe; int reps; bit pend; bit tog; bit ack; } swap_vec_t;
  swap_vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.wr_valid  = 1'b0;
    bus.wr_lane   = '0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
    bus.frame_end = 1'b0;
    bus.swap_req  = 1'b0;
    bus.clear_req = 1'b0;
  endtask

  task automatic tick();
    bit rdy_e, commit, busy_pre;
    rd_t t;
    rdy_e    = !rst && clr_m == 0;
    commit   = !rst && pend_m && bus.frame_end && clr_m == 0;
    busy_pre = clr_m > 0;
    #1;
    chk("wr_ready", bus.wr_ready, rdy_e);
    chk("swap_ack", bus.swap_ack, commit);
    ack_seen = bus.swap_ack;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      front_m = 0; pend_m = 0; clr_m = 0; rq.delete(); last_m = '0;
    end else begin
      if (bus.wr_valid && rdy_e)
        mem_m[!front_m][bus.wr_lane][bus.wr_addr] = bus.wr_data;
      if (bus.rd_en) begin
        t.due = edge_n + LAT - 1;
        for (int l = 0; l < LANES; l++) t.d[l*DW +: DW] = mem_m[front_m][l][bus.rd_addr];
        rq.push_back(t);
      end
      if (commit) begin front_m = !front_m; pend_m = 0; end
      else if (bus.swap_req) pend_m = 1;
`ifdef MULTIMEM_DBUF_CLEAR_EN
      if (busy_pre) clr_m--;
      else if (bus.clear_req) begin
        clr_m = DEPTH;
        for (int l = 0; l < LANES; l++)
          for (int a = 0; a < DEPTH; a++) mem_m[!front_m][l][a] = CV;
      end
`endif
    end
    #1;
    chk("front_sel", bus.front_sel, front_m);
    chk("swap_pending", bus.swap_pending, pend_m);
    chk("clear_busy", bus.clear_busy, clr_m > 0);
    if (rq.size() > 0 && rq[0].due == edge_n) begin
      last_m = rq[0].d;
      void'(rq.pop_front());
      chk("rd_valid", bus.rd_valid, 1);
    end else begin
      chk("rd_valid", bus.rd_valid, 0);
    end
    chk("rd_data", bus.rd_data, last_m);
  endtask

  task automatic do_swap();
    idle(); bus.swap_req = 1'b1; tick();
    idle(); bus.frame_end = 1'b1; tick();
    idle();
  endtask

  initial begin
    logic [31:0] r;
    bit f0;
    int n;
    checks = 0; failures = 0; edge_n = 0; last_m = '0;
    front_m = 0; pend_m = 0; clr_m = 0;

    tbl[0] = '{1, 0, 1,   1, 0, 0};
    tbl[1] = '{0, 0, 100, 1, 0, 0};
    tbl[2] = '{1, 0, 1,   1, 0, 0};
    tbl[3] = '{0, 1, 1,   0, 1, 1};
    tbl[4] = '{0, 1, 1,   0, 1, 0};
    tbl[5] = '{1, 1, 1,   1, 1, 0};
    tbl[6] = '{0, 1, 1,   0, 0, 1};

    idle();
    rst = 1'b1; tick(); tick();
    chk("reset_front", bus.front_sel, 0);
    chk("reset_rd_data", bus.rd_data, 0);
    rst = 1'b0;

    // Fill both buffers so every later read has a defined expectation.
    for (int b = 0; b < 2; b++) begin
      for (int l = 0; l < LANES; l++)
        for (int a = 0; a < DEPTH; a++) begin
          idle(); r = $urandom;
          bus.wr_valid = 1'b1; bus.wr_lane = l[LSB-1:0];
          bus.wr_addr = a[AB-1:0]; bus.wr_data = r[DW-1:0];
          tick();
        end
      do_swap();
    end

    // Lane 3 / addr 5 write, arm with same-cycle frame_end, commit later, read back.
    idle(); bus.wr_valid = 1'b1; bus.wr_lane = 3; bus.wr_addr = 5; bus.wr_data = 8'hA5; tick();
    idle(); tick(); tick(); tick();
    f0 = front_m;
    bus.swap_req = 1'b1; bus.frame_end = 1'b1; tick();
    chk("tp1_arm_only", bus.front_sel, f0);
    idle(); bus.frame_end = 1'b1; tick();
    idle(); bus.rd_en = 1'b1; bus.rd_addr = 5; tick();
    idle(); tick(); tick(); tick();
    chk("tp1_lane3", bus.rd_data[3*DW +: DW], 8'hA5);

    // Swap protocol table.
    f0 = front_m;
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].reps; k++) begin
        idle(); bus.swap_req = tbl[i].sr; bus.frame_end = tbl[i].fe; tick();
        chk($sformatf("tbl%0d_ack", i), ack_seen, tbl[i].ack);
        chk($sformatf("tbl%0d_pend", i), bus.swap_pending, tbl[i].pend);
        chk($sformatf("tbl%0d_front", i), bus.front_sel, f0 ^ tbl[i].tog);
      end
    end

    // Back-to-back reads straddling a commit.
    idle(); bus.swap_req = 1'b1; tick();
    f0 = front_m; n = 0;
    for (int i = 0; i < 10 + LAT; i++) begin
      idle(); r = $urandom;
      if (i < 10) begin bus.rd_en = 1'b1; bus.rd_addr = r[AB-1:0]; end
      bus.frame_end = (i == 4);
      tick();
      if (bus.rd_valid) n++;
    end
    chk("stream_count", n, 10);
    chk("stream_front", bus.front_sel, !f0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      idle(); r = $urandom;
      bus.wr_valid  = !pend_m && r[1:0] != 0;
      bus.wr_lane   = r[4:2];
      bus.wr_addr   = r[8:5];
      bus.wr_data   = r[16:9];
      bus.rd_en     = r[17];
      bus.rd_addr   = r[21:18];
      bus.swap_req  = r[26:22] == 0;
      bus.frame_end = r[29:27] == 0;
      bus.clear_req = $urandom_range(0, 199) == 0;
      tick();
    end
    idle(); for (int i = 0; i < LAT; i++) tick();

`ifdef MULTIMEM_DBUF_CLEAR_EN
    wait (clr_m == 0);
    idle(); bus.clear_req = 1'b1; tick();
    idle(); n = 0;
    while (bus.clear_busy && n < 100) begin n++; tick(); end
    chk("clear_len", n, DEPTH);
    do_swap();
    for (int a = 0; a < DEPTH; a++) begin
      idle(); bus.rd_en = 1'b1; bus.rd_addr = a[AB-1:0]; tick();
      idle(); tick(); tick(); tick();
      chk($sformatf("clear_rd%0d", a), bus.rd_data, {LANES{CV}});
    end

    f0 = front_m;
    idle(); bus.clear_req = 1'b1; tick();
    idle(); for (int i = 0; i < 4; i++) tick();
    bus.swap_req = 1'b1; bus.frame_end = 1'b1; tick();
    idle(); bus.frame_end = 1'b1; tick();
    chk("clear_hold_front", bus.front_sel, f0);
    chk("clear_hold_pend", bus.swap_pending, 1);
    idle(); n = 0;
    while (bus.clear_busy && n < 100) begin n++; tick(); end
    chk("clear_end_bound", n < 100, 1);
    bus.frame_end = 1'b1; tick();
    chk("clear_commit_ack", ack_seen, 1);
    chk("clear_commit_front", bus.front_sel, !f0);
    idle(); tick();
`else
    idle(); bus.clear_req = 1'b1; tick();
    chk("noclear_busy", bus.clear_busy, 0);
    idle(); tick();
`endif

    // Reset landing in the middle of a clear, with reads in flight.
    idle(); bus.clear_req = 1'b1; tick();
    for (int i = 0; i < 6; i++) begin idle(); bus.rd_en = 1'b1; tick(); end
    idle(); rst = 1'b1; tick();
    chk("rst_clear_busy", bus.clear_busy, 0);
    chk("rst_front", bus.front_sel, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    rst = 1'b0;
    #1;
    chk("rst_wr_ready", bus.wr_ready, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
